// File: rtl/f_pc_npc_if.sv
// F-stage PC / next-PC bundle between the D-stage decode side (master) and
// the PC block (slave). Optional macro: PC_ALIGN_CHECK_EN adds F_AdEL.
interface f_pc_npc_if;
  logic        en;
  logic [1:0]  NPCOp;
  logic        Branch_or_not;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [31:0] jr_target;
  logic [31:0] F_PC;
  logic [31:0] F_NPC;
  logic        redirect;
`ifdef PC_ALIGN_CHECK_EN
  logic        F_AdEL;
`endif

  modport master (
`ifdef PC_ALIGN_CHECK_EN
    input  F_AdEL,
`endif
    output en, NPCOp, Branch_or_not, D_PC, D_instr, jr_target,
    input  F_PC, F_NPC, redirect
  );

  modport slave (
`ifdef PC_ALIGN_CHECK_EN
    output F_AdEL,
`endif
    input  en, NPCOp, Branch_or_not, D_PC, D_instr, jr_target,
    output F_PC, F_NPC, redirect
  );
endinterface

// File: rtl/f_pc_npc.sv
// F-stage program counter and next-PC select for the 5-stage MIPS pipeline.
// Redirects come from the instruction in D, so they land on the fetch after
// the delay slot (which already sits in F). A stall holds F_PC; D is frozen by
// the same stall, so a pending redirect is simply re-presented later and no
// pending-redirect state is kept here.
// Optional macro: PC_ALIGN_CHECK_EN adds the F_AdEL fetch-address check and
// the jump to EXC_PC when it fires.
module f_pc_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
`endif
) (
  input  logic       clk,
  input  logic       reset,
  f_pc_npc_if.slave  pif
);

  localparam logic [1:0] OP_SEQ = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  localparam logic [1:0] OP_JR  = 2'b11;

  // Candidate targets formed from the D-stage instruction.
  typedef struct packed {
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] jr;
  } tgt_t;

  logic [31:0] f_pc_q;
  logic [31:0] f_pc_d;
  logic [31:0] f_pc_plus4;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_off;
  tgt_t        tgt;
  logic [31:0] npc;
  logic        redir;
  logic        adel;

  // Opcode/function bits of D_instr are decoded upstream, not here.
  logic unused_instr_hi;
  assign unused_instr_hi = ^pif.D_instr[31:26];

  // Target formation; all adds wrap modulo 2^32.
  always_comb begin
    f_pc_plus4 = f_pc_q + 32'd4;
    d_pc_plus4 = pif.D_PC + 32'd4;
    br_off     = {{14{pif.D_instr[15]}}, pif.D_instr[15:0], 2'b00};
    tgt.br     = d_pc_plus4 + br_off;
    tgt.jmp    = {d_pc_plus4[31:28], pif.D_instr[25:0], 2'b00};
    tgt.jr     = pif.jr_target;
  end

  // Next-PC select and redirect flag; an untaken branch falls through.
  always_comb begin
    npc   = f_pc_plus4;
    redir = 1'b0;
    case (pif.NPCOp)
      OP_SEQ: begin
        npc   = f_pc_plus4;
        redir = 1'b0;
      end
      OP_BR: begin
        if (pif.Branch_or_not) begin
          npc   = tgt.br;
          redir = 1'b1;
        end
      end
      OP_J: begin
        npc   = tgt.jmp;
        redir = 1'b1;
      end
      OP_JR: begin
        npc   = tgt.jr;
        redir = 1'b1;
      end
      default: begin
        npc   = f_pc_plus4;
        redir = 1'b0;
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned or out-of-IMEM fetch address.
  always_comb begin
    adel = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_LO) || (f_pc_q > IMEM_HI);
  end
`else
  // No address check in this build.
  always_comb begin
    adel = 1'b0;
  end
`endif

  // PC update priority below reset: exception, stall hold, advance.
  always_comb begin
    f_pc_d = f_pc_q;
`ifdef PC_ALIGN_CHECK_EN
    if (adel) begin
      f_pc_d = EXC_PC;
    end else if (pif.en) begin
      f_pc_d = npc;
    end
`else
    if (adel || pif.en) begin
      f_pc_d = npc;
    end
`endif
  end

  // PC register with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_pc_q <= RESET_PC;
    end else begin
      f_pc_q <= f_pc_d;
    end
  end

  assign pif.F_PC     = f_pc_q;
  assign pif.F_NPC    = npc;
  assign pif.redirect = redir;
`ifdef PC_ALIGN_CHECK_EN
  assign pif.F_AdEL   = adel;
`endif

endmodule

// File: tb/tb_f_pc_npc.sv
// Bench for f_pc_npc: directed scenarios plus randomized cycles, each checked
// against a cycle-level reference model of the fetch PC.
module tb_f_pc_npc;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] m_pc;

  f_pc_npc_if pif ();

  f_pc_npc dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_adel(input logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
    return (pc % 4 != 0) || (pc < IMEM_LO) || (pc > IMEM_HI);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, check combinational view of the current PC,
  // then advance the model the way the edge should.
  task automatic step(input logic rst, input logic e, input logic [1:0] op,
                      input logic bt, input logic [31:0] dpc,
                      input logic [31:0] din, input logic [31:0] jrt);
    logic [31:0] seq, d4, br, jmp, exp_npc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic        exp_red;
    reset             = rst;
    pif.en            = e;
    pif.NPCOp         = op;
    pif.Branch_or_not = bt;
    pif.D_PC          = dpc;
    pif.D_instr       = din;
    pif.jr_target     = jrt;
    #1;
    imm = din[15:0];
    idx = din[25:0];
    seq = m_pc + 4;
    d4  = dpc + 4;
    br  = d4 + 32'($signed(imm)) * 4;
    jmp = (d4 & 32'hF000_0000) + 32'(idx) * 4;
    if (op == 2'd1 && bt)      begin exp_npc = br;  exp_red = 1'b1; end
    else if (op == 2'd2)       begin exp_npc = jmp; exp_red = 1'b1; end
    else if (op == 2'd3)       begin exp_npc = jrt; exp_red = 1'b1; end
    else                       begin exp_npc = seq; exp_red = 1'b0; end
    chk("F_PC", pif.F_PC, m_pc);
    chk("F_NPC", pif.F_NPC, exp_npc);
    chk("redirect", {31'd0, pif.redirect}, {31'd0, exp_red});
`ifdef PC_ALIGN_CHECK_EN
    chk("F_AdEL", {31'd0, pif.F_AdEL}, {31'd0, model_adel(m_pc)});
`endif
    if (!rst)                 m_pc = RESET_PC;
    else if (model_adel(m_pc)) m_pc = EXC_PC;
    else if (e)               m_pc = exp_npc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    pif.en = 1'b1; pif.NPCOp = 2'd0; pif.Branch_or_not = 1'b0;
    pif.D_PC = '0; pif.D_instr = '0; pif.jr_target = '0;
    @(posedge clk);
    @(negedge clk);
    m_pc = RESET_PC;

    // 1: second reset cycle, then sequential fetch
    step(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("t1_rst", pif.F_PC, 32'h3000);
    step(1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("t1_a", pif.F_PC, 32'h3004);
    step(1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("t1_b", pif.F_PC, 32'h300C);
    // 2: taken backward branch
    step(1'b1, 1'b1, 2'd1, 1'b1, 32'h3008, 32'h0000_FFFE, 32'h0);
    chk("t2", pif.F_PC, 32'h3004);
    // 3: back to 0x300C via jr, then untaken branch
    step(1'b1, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h300C);
    step(1'b1, 1'b1, 2'd1, 1'b0, 32'h3008, 32'h0000_FFFE, 32'h0);
    chk("t3", pif.F_PC, 32'h3010);
    // 4/5: stalled jump then release
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0000_0C10, 32'h0);
    chk("t4_hold", pif.F_PC, 32'h3010);
    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h3000, 32'h0000_0C10, 32'h0);
    chk("t5_j", pif.F_PC, 32'h3040);
    step(1'b1, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h3100);
    chk("t5_jr", pif.F_PC, 32'h3100);
    // reset during a stalled redirect
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0000_0C10, 32'h0);
    step(1'b0, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0000_0C10, 32'h0);
    chk("rst_stall", pif.F_PC, 32'h3000);
`ifdef PC_ALIGN_CHECK_EN
    // 6: misaligned jr target traps to handler
    step(1'b1, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h3002);
    chk("t6_pc", pif.F_PC, 32'h3002);
    chk("t6_adel", {31'd0, pif.F_AdEL}, 32'd1);
    step(1'b1, 1'b0, 2'd0, 1'b0, 32'h3000, 32'h0, 32'h0);
    chk("t6_exc", pif.F_PC, 32'h4180);
`else
    // wrap of F_PC+4 at the top of the address space
    step(1'b1, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 2'd0, 1'b0, 32'h3000, 32'h0, 32'h0);
    chk("wrap", pif.F_PC, 32'h0000_0000);
`endif

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] dpc, jrt;
      dpc = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 4095) * 4));
      jrt = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 4095) * 4));
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), dpc, $urandom, jrt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
